// File: rtl/wb_stage.sv
// wb_stage -- writeback/commit stage.
//
// Retires one instruction per commit event (s_valid && s_ready). It drives the
// integer register file write port and owns the machine CSRs (mstatus, mtvec,
// mepc, mcause). It also performs ecall trap entry and hands the committed
// next PC to IF over a valid/ready handshake.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. The sender holds valid and its payload stable until
// that edge. The receiver may change ready freely.
//   s_valid/s_ready : upstream M->W bus register -> this stage (commit)
//   m_valid/m_ready : this stage -> IF (next_pc redirect)
//
// Optional build macro WB_INSTRET_EN adds a 64-bit instret counter at CSR
// 0xB02 (low) / 0xB82 (high).
//
// Ports:
//   clk, rst (async, active-low)
//   pcW, dnpcW, snpcW, ALU_resultW, mdataW, csrW, rdregsrcW, csraddrW, rdW,
//   ecallW, cmp_resultW : committed instruction fields
//   s_valid/s_ready     : commit handshake
//   rf_wen/rf_waddr/rf_wdata : register file write port (combinational)
//   mepc_o, mtvec_o     : current CSR values
//   m_valid/m_ready/next_pc  : redirect to IF
//   state_dbg           : FSM state (0 IDLE, 1 REDIRECT)
module wb_stage #(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] ECALL_CAUSE   = 32'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcW,
  input  logic [31:0] dnpcW,
  input  logic [31:0] snpcW,
  input  logic [31:0] ALU_resultW,
  input  logic [31:0] mdataW,
  input  logic [31:0] csrW,
  input  logic [2:0]  rdregsrcW,
  input  logic [11:0] csraddrW,
  input  logic [4:0]  rdW,
  input  logic        ecallW,
  input  logic        cmp_resultW,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] mepc_o,
  output logic [31:0] mtvec_o,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] next_pc,
  output logic [0:0]  state_dbg
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
`ifdef WB_INSTRET_EN
  localparam logic [11:0] A_INSTRET  = 12'hB02;
  localparam logic [11:0] A_INSTRETH = 12'hB82;
`endif

  logic [0:0]  state;
  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic        commit;
  logic        csr_wr;
  logic [31:0] csr_rdata;

`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  assign state_dbg = state;
  assign s_ready   = (state == ST_IDLE);
  assign m_valid   = (state == ST_REDIRECT);
  assign mepc_o    = mepc;
  assign mtvec_o   = mtvec;

  // s_ready is high during reset (state is IDLE), so gate on rst to keep
  // a commit from leaking out while reset is asserted.
  assign commit = s_valid && s_ready && rst;

  // CSR write from the instruction; ecall suppresses it.
  assign csr_wr = commit && !ecallW && (rdregsrcW == 3'd4);

  always_comb begin
    csr_rdata = 32'h0;
    case (csraddrW)
      A_MSTATUS:  csr_rdata = mstatus;
      A_MTVEC:    csr_rdata = mtvec;
      A_MEPC:     csr_rdata = mepc;
      A_MCAUSE:   csr_rdata = mcause;
`ifdef WB_INSTRET_EN
      A_INSTRET:  csr_rdata = instret[31:0];
      A_INSTRETH: csr_rdata = instret[63:32];
`endif
      default:    csr_rdata = 32'h0;
    endcase
  end

  always_comb begin
    rf_wdata = 32'h0;
    case (rdregsrcW)
      3'd1:    rf_wdata = ALU_resultW;
      3'd2:    rf_wdata = mdataW;
      3'd3:    rf_wdata = snpcW;
      3'd4:    rf_wdata = csr_rdata;
      3'd5:    rf_wdata = {31'b0, cmp_resultW};
      default: rf_wdata = 32'h0;
    endcase
  end

  assign rf_waddr = rdW;
  assign rf_wen   = commit && (rdregsrcW >= 3'd1) && (rdregsrcW <= 3'd5) &&
                    (rdW != 5'd0) && !ecallW;

  // Commit/redirect FSM; next_pc is captured on the commit edge and held
  // until IF accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      next_pc <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: if (commit) begin
          state   <= ST_REDIRECT;
          next_pc <= ecallW ? mtvec : dnpcW;
        end
        ST_REDIRECT: if (m_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus <= RESET_MSTATUS;
      mtvec   <= 32'h0;
      mepc    <= 32'h0;
      mcause  <= 32'h0;
    end else if (commit && ecallW) begin
      mepc   <= pcW;
      mcause <= ECALL_CAUSE;
    end else if (csr_wr) begin
      case (csraddrW)
        A_MSTATUS: mstatus <= csrW;
        A_MTVEC:   mtvec   <= csrW;
        A_MEPC:    mepc    <= csrW;
        A_MCAUSE:  mcause  <= csrW;
        default:   ;
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  // A software write to either half replaces that half and suppresses the
  // increment for that commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret <= 64'h0;
    end else if (commit) begin
      if (csr_wr && csraddrW == A_INSTRET)
        instret[31:0] <= csrW;
      else if (csr_wr && csraddrW == A_INSTRETH)
        instret[63:32] <= csrW;
      else
        instret <= instret + 64'd1;
    end
  end
`endif

endmodule
